// File: rtl/real_arith32.sv
// real_arith32: pipelined binary32 add/sub/mul with DAZ/FTZ and IEEE exception flags.
// Define REAL_ARITH32_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module real_arith32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] result,
    output logic [3:0]  flags
);
    localparam logic [31:0] qnan = 32'h7FC0_0000;

    logic        v0, v1, sp1, s1;
    logic [1:0]  op0;
    logic [31:0] a0, b0, sp_res1;
    logic [3:0]  sp_fl1;
    logic [9:0]  e1;
    logic [26:0] m1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v0 <= 1'b0; op0 <= 2'd0; a0 <= '0; b0 <= '0;
        end else begin
            v0 <= in_valid;
            if (in_valid) begin op0 <= op; a0 <= a; b0 <= b; end
        end

    logic        sa, sb, za, zb, ia, ib, na, nb, snan, is_mul, eff_sub, swap, sx;
    logic [7:0]  ea, eb, ex, d;
    logic [23:0] ma, mb, mx, my;
    assign is_mul  = op0 == 2'b10;
    assign sa      = a0[31];
    assign sb      = b0[31] ^ (op0 == 2'b01);
    assign ea      = a0[30:23];
    assign eb      = b0[30:23];
    assign za      = ea == 8'd0;
    assign zb      = eb == 8'd0;
    assign ia      = &ea && a0[22:0] == 23'd0;
    assign ib      = &eb && b0[22:0] == 23'd0;
    assign na      = &ea && |a0[22:0];
    assign nb      = &eb && |b0[22:0];
    assign snan    = (na && !a0[22]) || (nb && !b0[22]);
    assign ma      = {1'b1, a0[22:0]};
    assign mb      = {1'b1, b0[22:0]};
    assign eff_sub = sa ^ sb;
    assign swap    = b0[30:0] > a0[30:0];
    assign sx      = swap ? sb : sa;
    assign ex      = swap ? eb : ea;
    assign d       = swap ? eb - ea : ea - eb;
    assign mx      = swap ? mb : ma;
    assign my      = swap ? ma : mb;

    // Smaller operand carries guard/round plus a sticky bit of everything shifted past them.
    logic [26:0] ys, al, add_m, mul_m;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  add_e, mul_e;
    logic [47:0] p;
    assign ys  = {my, 3'b000} >> d;
    assign al  = {ys[26:1], ys[0] | ((ys << d) != {my, 3'b000})};
    assign sum = eff_sub ? {1'b0, mx, 3'b000} - {1'b0, al} : {1'b0, mx, 3'b000} + {1'b0, al};
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 27; i++) lz = sum[i] ? 5'(26 - i) : lz;
    end
    assign add_m = sum[27] ? {sum[27:2], |sum[1:0]} : sum[26:0] << lz;
    assign add_e = sum[27] ? {2'b00, ex} + 10'd1 : {2'b00, ex} - {5'd0, lz};
    assign p     = ma * mb;
    assign mul_m = p[47] ? {p[47:22], |p[21:0]} : {p[46:21], |p[20:0]};
    assign mul_e = {2'b00, ea} + {2'b00, eb} - 10'd127 + {9'd0, p[47]};

    logic        sp;
    logic [31:0] sp_res;
    logic [3:0]  sp_fl;
    always_comb begin
        sp = 1'b1;
        sp_res = qnan;
        sp_fl = 4'b0000;
        if (op0 == 2'b11 || snan) sp_fl = 4'b1000;
        else if (!na && !nb) begin
            if (is_mul) begin
                if ((ia && zb) || (za && ib)) sp_fl = 4'b1000;
                else if (ia || ib) sp_res = {sa ^ sb, 31'h7F80_0000};
                else if (za || zb) sp_res = {sa ^ sb, 31'd0};
                else sp = 1'b0;
            end else begin
                if (ia && ib && eff_sub) sp_fl = 4'b1000;
                else if (ia) sp_res = a0;
                else if (ib) sp_res = {sb, b0[30:0]};
                else if (za && zb) sp_res = {sa & sb, 31'd0};
                else if (za) sp_res = {sb, b0[30:0]};
                else if (zb) sp_res = a0;
                else if (sum == 28'd0) sp_res = 32'd0;
                else sp = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v1 <= 1'b0; sp1 <= 1'b0; sp_res1 <= '0; sp_fl1 <= '0; s1 <= 1'b0; e1 <= '0; m1 <= '0;
        end else begin
            v1 <= v0;
            if (v0) begin
                sp1 <= sp; sp_res1 <= sp_res; sp_fl1 <= sp_fl;
                s1 <= is_mul ? sa ^ sb : sx;
                e1 <= is_mul ? mul_e : add_e;
                m1 <= is_mul ? mul_m : add_m;
            end
        end

    logic        inc, nx;
    logic [24:0] mr;
    logic [9:0]  er;
    logic [31:0] res_n;
    logic [3:0]  fl_n;
`ifdef REAL_ARITH32_RNE_EN
    assign inc = m1[2] && (m1[1] || m1[0] || m1[3]);
`else
    assign inc = 1'b0;
`endif
    assign mr = {1'b0, m1[26:3]} + {24'd0, inc};
    assign er = e1 + {9'd0, mr[24]};
    assign nx = |m1[2:0];
    always_comb begin
        res_n = {s1, er[7:0], mr[24] ? mr[23:1] : mr[22:0]};
        fl_n = {3'b000, nx};
        if (sp1) begin
            res_n = sp_res1;
            fl_n = sp_fl1;
        end else if (er[9] || er == 10'd0) begin
            res_n = {s1, 31'd0};
            fl_n = 4'b0011;
        end else if (er >= 10'd255) begin
`ifdef REAL_ARITH32_RNE_EN
            res_n = {s1, 31'h7F80_0000};
`else
            res_n = {s1, 31'h7F7F_FFFF};
`endif
            fl_n = 4'b0101;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid <= 1'b0; result <= '0; flags <= '0;
        end else begin
            out_valid <= v1;
            if (v1) begin result <= res_n; flags <= fl_n; end
        end
endmodule

// File: tb/tb_real_arith32.sv
// tb_real_arith32: directed-vector check of real_arith32 latency, arithmetic, specials and reset.
module tb_real_arith32;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_valid;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, result;
    logic [3:0]  flags;
    int          total = 0, bad = 0;

`ifdef REAL_ARITH32_RNE_EN
    localparam logic [31:0] sum_e = 32'h40C3_3334, ovf_e = 32'h7F80_0000, tie_odd_e = 32'h3F80_0002;
`else
    localparam logic [31:0] sum_e = 32'h40C3_3333, ovf_e = 32'h7F7F_FFFF, tie_odd_e = 32'h3F80_0001;
`endif

    real_arith32 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input logic [3:0] ef);
        @(negedge clk); in_valid = 1'b1; op = o; a = x; b = y;
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_v"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_r"}, result, er);
        chk({tag, "_f"}, {28'd0, flags}, {28'd0, ef});
    endtask

    logic [1:0]  bop [3] = '{2'b00, 2'b01, 2'b10};
    logic [31:0] ba  [3] = '{32'h4019_999A, 32'h406C_CCCD, 32'h4000_0000};
    logic [31:0] bb  [3] = '{32'h406C_CCCD, 32'h4019_999A, 32'h4040_0000};
    logic [31:0] bres[3];
    logic [8:0]  ov;
    logic [31:0] rs  [9];
    int          seen;

    initial begin
        bres = '{sum_e, 32'h3FA6_6666, 32'h40C0_0000};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_v", {31'd0, out_valid}, 32'd0);
        chk("rst_r", result, 32'd0);
        chk("rst_f", {28'd0, flags}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run("add24_37", 2'b00, 32'h4019_999A, 32'h406C_CCCD, sum_e, 4'b0001);
        run("sub37_24", 2'b01, 32'h406C_CCCD, 32'h4019_999A, 32'h3FA6_6666, 4'b0000);
        run("mul2x3", 2'b10, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000);
        run("mul15sq", 2'b10, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000);
        run("add1p2", 2'b00, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000);
        run("cancel", 2'b01, 32'h3F80_0001, 32'h3F80_0000, 32'h3400_0000, 4'b0000);
        run("tie_even", 2'b00, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 4'b0001);
        run("tie_odd", 2'b00, 32'h3F80_0001, 32'h3380_0000, tie_odd_e, 4'b0001);
        run("inf_inf", 2'b01, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000);
        run("mul_ovf", 2'b10, 32'h7F7F_FFFF, 32'h4000_0000, ovf_e, 4'b0101);
        run("add_ovf", 2'b00, 32'h7F7F_FFFF, 32'h7F7F_FFFF, ovf_e, 4'b0101);
        run("mul_unf", 2'b10, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011);
        run("op11", 2'b11, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000);
        run("qnan", 2'b00, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b0000);
        run("snan", 2'b00, 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000);
        run("zero_inf", 2'b10, 32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b1000);
        run("ninf_p1", 2'b00, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 4'b0000);
        run("nz_nz", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 4'b0000);
        run("one_m1", 2'b01, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4'b0000);
        run("neg_x0", 2'b10, 32'hC000_0000, 32'h0000_0000, 32'h8000_0000, 4'b0000);
        run("daz", 2'b00, 32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000);

        repeat (2) @(posedge clk);
        #1;
        chk("hold_v", {31'd0, out_valid}, 32'd0);
        chk("hold_r", result, 32'h3F80_0000);
        chk("hold_f", {28'd0, flags}, 32'd0);

        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            in_valid = k < 3;
            if (k < 3) begin op = bop[k]; a = ba[k]; b = bb[k]; end
            @(posedge clk); #1;
            ov[k] = out_valid;
            rs[k] = result;
        end
        chk("b2b_vpat", {23'd0, ov}, 32'h0000_001C);
        for (int j = 0; j < 3; j++) chk($sformatf("b2b_r%0d", j), rs[j + 2], bres[j]);

        @(negedge clk); in_valid = 1'b1; op = 2'b00; a = 32'h3F80_0000; b = 32'h4000_0000;
        @(negedge clk); op = 2'b10; a = 32'h4000_0000; b = 32'h4040_0000;
        @(negedge clk); in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_v", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_r", result, 32'd0);
        chk("mid_rst_f", {28'd0, flags}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("rst_stale", seen, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
